// File: rtl/bg_pixel_fetch.sv
// bg_pixel_fetch: raster background fetch from word memory into a ready/valid pixel stream.
// Optional horizontal scroll via macro BG_FETCH_SCROLL_EN (adds scroll_x input).
module bg_pixel_fetch #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
`ifdef BG_FETCH_SCROLL_EN
  input  logic [9:0]  scroll_x,
`endif
  output logic [18:0] mem_address,
  output logic        mem_chipselect,
  output logic        mem_clken,
  output logic        mem_write,
  output logic [7:0]  mem_writedata,
  input  logic [7:0]  mem_readdata,
  output logic [7:0]  pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        busy
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);
  localparam logic [AW+1:0] DEPTH = (AW+2)'(FIFO_DEPTH);

  logic [1:0]    state;
  logic [9:0]    x, y;
  logic [AW:0]   count;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [9:0]    fifo [FIFO_DEPTH];
  logic          inflight, tag_sof, tag_eol, issue, pop, last, x_end;

  // in-flight read counts against capacity so a returning word always has a slot
  assign issue = (state == FETCH) && (({1'b0, count} + (AW+2)'(inflight)) < DEPTH);
  assign x_end = x == X_LAST;
  assign last = x_end && (y == Y_LAST);
  assign pop = pix_valid && pix_ready;
  assign pix_valid = count != '0;
  assign {pix_sof, pix_eol, pix_data} = pix_valid ? fifo[rd_ptr] : '0;
  assign mem_chipselect = issue;
  assign mem_write = 1'b0;
  assign mem_writedata = 8'd0;
  assign busy = (state != IDLE) || pix_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      x <= '0;
      y <= '0;
      inflight <= 1'b0;
      tag_sof <= 1'b0;
      tag_eol <= 1'b0;
      mem_clken <= 1'b0;
    end else begin
      mem_clken <= 1'b1;
      inflight <= issue;
      state <= state == IDLE  ? (frame_start ? FETCH : IDLE) :
               state == FETCH ? (issue && last ? DRAIN : FETCH) :
               (!pix_valid && !inflight ? IDLE : DRAIN);
      if (issue) begin
        tag_sof <= (x == '0) && (y == '0);
        tag_eol <= x_end;
        x <= x_end ? '0 : x + 10'd1;
        y <= last ? '0 : x_end ? y + 10'd1 : y;
      end
    end
  end

`ifdef BG_FETCH_SCROLL_EN
  localparam logic [9:0] X_H = 10'(H_ACTIVE);
  logic [9:0]  col, col0;
  logic [18:0] base;
  assign mem_address = base + 19'(col);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      col0 <= '0;
      base <= '0;
    end else if (state == IDLE && frame_start) begin
      col <= scroll_x % X_H;
      col0 <= scroll_x % X_H;
    end else if (issue) begin
      col <= x_end ? col0 : (col == X_LAST ? '0 : col + 10'd1);
      base <= last ? '0 : x_end ? base + 19'(H_ACTIVE) : base;
    end
  end
`else
  logic [18:0] addr;
  assign mem_address = addr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr <= '0;
    else if (issue) addr <= last ? '0 : addr + 19'd1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (inflight) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(inflight) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk)
    if (inflight) fifo[wr_ptr] <= {tag_sof, tag_eol, mem_readdata};
endmodule

// File: tb/tb_bg_pixel_fetch.sv
// tb_bg_pixel_fetch: directed and random-backpressure checks of bg_pixel_fetch in a 4x2 configuration.
module tb_bg_pixel_fetch;
  localparam int H = 4, V = 2, N = H * V;
  logic clk = 0, rst_n = 1, frame_start = 0, pix_ready = 0;
  logic [18:0] mem_address;
  logic mem_chipselect, mem_clken, mem_write, pix_valid, pix_sof, pix_eol, busy;
  logic [7:0] mem_writedata, mem_readdata, pix_data;
  logic [7:0] salt = 0;
  int scroll = 0;
`ifdef BG_FETCH_SCROLL_EN
  logic [9:0] scroll_x = 0;
`endif
  int checks = 0, errors = 0, cyc = 0;
  logic [9:0] pq[$];
  int tq[$];
  int aq[$];

  bg_pixel_fetch #(.H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
`ifdef BG_FETCH_SCROLL_EN
    .scroll_x(scroll_x),
`endif
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_clken(mem_clken),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .busy(busy));

  always #5 clk = ~clk;

  // memory word = address (plus a per-frame salt), returned one cycle after the read
  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_readdata <= 8'(mem_address) + salt;
  end

  always @(negedge clk) if (rst_n) begin
    if (pix_valid && pix_ready) begin
      pq.push_back({pix_sof, pix_eol, pix_data});
      tq.push_back(cyc);
    end
    if (mem_chipselect) aq.push_back(int'(mem_address));
  end

  function automatic int exp_addr(int k);
    return (k / H) * H + ((k % H) + scroll) % H;
  endfunction

  function automatic logic [9:0] exp_pix(int k);
    return {k == 0, (k % H) == H - 1, 8'(exp_addr(k)) + salt};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame;
    pq.delete();
    tq.delete();
    aq.delete();
    frame_start = 1;
    tick;
    frame_start = 0;
  endtask

  task automatic run_frame(input bit rnd, input string tag);
    int n = 0;
    while (busy && n < 2000) begin
      if (rnd) pix_ready = 1'($urandom % 2);
      tick;
      n++;
    end
    pix_ready = 1;
    chk($sformatf("%s_done", tag), busy, 0);
    chk($sformatf("%s_npix", tag), pq.size(), N);
    chk($sformatf("%s_nrd", tag), aq.size(), N);
    for (int k = 0; k < N; k++) begin
      if (k < pq.size()) chk($sformatf("%s_pix%0d", tag, k), pq[k], exp_pix(k));
      if (k < aq.size()) chk($sformatf("%s_adr%0d", tag, k), aq[k], exp_addr(k));
    end
  endtask

  task automatic chk_zero(string tag);
    chk($sformatf("%s_ctl", tag),
        {pix_valid, pix_sof, pix_eol, mem_chipselect, mem_clken, busy, mem_write}, 0);
    chk($sformatf("%s_dat", tag), {pix_data, mem_writedata}, 0);
    chk($sformatf("%s_adr", tag), mem_address, 0);
  endtask

  initial begin
    int lat, n;
    #1 rst_n = 0;
    #2 chk_zero("rst");
    tick;
    tick;
    rst_n = 1;
    chk("clken_held", mem_clken, 0);
    tick;
    chk("clken_up", mem_clken, 1);
    chk("idle_busy", busy, 0);

    // basic frame: latency, order, tags, full-rate streaming
    pix_ready = 1;
    start_frame;
    lat = 1;
    while (!pix_valid && lat < 20) begin
      tick;
      lat++;
    end
    chk("latency", lat, 3);
    run_frame(0, "basic");
    if (tq.size() == N) chk("thruput", tq[N-1] - tq[0], N - 1);

    // backpressure: FIFO fills, reads stop, stream resumes gap-free
    pix_ready = 0;
    start_frame;
    repeat (9) tick;
    chk("stall_reads", aq.size(), 4);
    chk("stall_cs", mem_chipselect, 0);
    chk("stall_valid", pix_valid, 1);
    pix_ready = 1;
    run_frame(0, "stall");
    if (tq.size() == N) chk("stall_gap", tq[N-1] - tq[0], N - 1);

    // frame_start during FETCH is ignored
    start_frame;
    tick;
    frame_start = 1;
    tick;
    frame_start = 0;
    run_frame(0, "refs");
    repeat (3) tick;
    chk("refs_extra", pq.size(), N);

    // mid-frame async reset
    start_frame;
    n = 0;
    while (pq.size() < 5 && n < 50) begin
      tick;
      n++;
    end
    chk("mid_reached", pq.size(), 5);
    rst_n = 0;
    #1 chk_zero("midrst");
    tick;
    rst_n = 1;
    tick;
    start_frame;
    run_frame(0, "after_rst");

`ifdef BG_FETCH_SCROLL_EN
    scroll = 3;
    scroll_x = 10'd3;
    start_frame;
    scroll_x = 10'd0;
    run_frame(0, "scroll3");
`endif

    // random backpressure and memory contents over many frames
    for (int f = 0; f < 15; f++) begin
      salt = 8'($urandom);
`ifdef BG_FETCH_SCROLL_EN
      scroll = $urandom_range(0, 9);
      scroll_x = 10'(scroll);
`endif
      pix_ready = 1'($urandom % 2);
      start_frame;
      run_frame(1, $sformatf("rnd%0d", f));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bg_pixel_fetch.md
BG_PIXEL_FETCH -- requirements
Module: bg_pixel_fetch

Interface
REQ-001 Parameters SHALL be: H_ACTIVE, default 640, pixels per line; V_ACTIVE, default 480, lines per frame; FIFO_DEPTH, default 4, output buffer entries (power of two, 2..16).
REQ-002 Port `clk`, input, 1 bit, SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port `rst_n`, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-004 Port `frame_start`, input, 1 bit, SHALL be a single-cycle pulse that requests a new frame fetch.
REQ-005 Port `mem_address`, output, 19 bits, SHALL be the background memory word address (address = y*H_ACTIVE + x).
REQ-006 Port `mem_chipselect`, output, 1 bit, SHALL be the memory read strobe, one read per asserted cycle.
REQ-007 Port `mem_clken`, output, 1 bit, SHALL be the memory clock enable, held 1 outside reset.
REQ-008 Ports `mem_write`, output, 1 bit, and `mem_writedata`, output, 8 bits, SHALL be tied to 0.
REQ-009 Port `mem_readdata`, input, 8 bits, SHALL carry the palette index, valid exactly 1 cycle after its chipselect cycle.
REQ-010 Ports `pix_data`, output, 8 bits, and `pix_valid`, output, 1 bit, SHALL be the output pixel stream.
REQ-011 Port `pix_ready`, input, 1 bit, SHALL be the consumer backpressure; a pixel transfers when pix_valid and pix_ready are both 1.
REQ-012 Ports `pix_sof`, output, 1 bit, and `pix_eol`, output, 1 bit, SHALL flag the first pixel of the frame and the last pixel of each line, aligned with pix_data.
REQ-013 Port `busy`, output, 1 bit, SHALL be 1 whenever the FSM is not IDLE or the FIFO is non-empty.

Function
REQ-014 FSM states SHALL be IDLE, FETCH and DRAIN.
- IDLE -> FETCH on frame_start.
- FETCH -> DRAIN after the read for (H_ACTIVE-1, V_ACTIVE-1) issues.
- DRAIN -> IDLE when the FIFO is empty and no read is in flight.
REQ-015 In FETCH, a read SHALL issue when (FIFO count + in-flight reads) < FIFO_DEPTH; when it does not issue, chipselect SHALL be 0.
REQ-016 The x/y counters SHALL advance only on an issued read: x wraps at H_ACTIVE-1 to 0 and increments y; address is a running linear counter, never a multiply.
REQ-017 Returned data SHALL be written to the FIFO the cycle after issue, tagged with sof (x=0, y=0) and eol (x=H_ACTIVE-1).
REQ-018 The FIFO SHALL present its head combinationally; a simultaneous push and pop at full or empty SHALL leave the count unchanged and lose no data.
REQ-019 Minimum latency from frame_start to first pix_valid SHALL be 3 cycles: FSM entry, read, FIFO write.
REQ-020 Sustained throughput SHALL be 1 pixel/cycle while pix_ready is held at 1.
REQ-021 A frame_start during FETCH or DRAIN SHALL be ignored; no restart and no counter change.
REQ-022 Pixel order SHALL be raster order, and exactly H_ACTIVE*V_ACTIVE pixels SHALL be delivered per frame.

Reset
REQ-023 When rst_n is 0, the following SHALL be forced immediately, regardless of clk: FSM = IDLE, x = y = address = 0, FIFO empty, in-flight cleared.
REQ-024 Under reset, all outputs SHALL be 0, including mem_clken; mem_clken returns to 1 on the first clock after release.
REQ-025 Reset asserted mid-frame SHALL discard buffered and in-flight pixels; the next frame_start begins at pixel (0,0).

Configuration
REQ-026 With macro BG_FETCH_SCROLL_EN defined:
- an added input `scroll_x`, 10 bits, SHALL be sampled on frame_start;
- the fetched column SHALL be (x + scroll_x) mod H_ACTIVE, with wrap inside the same line;
- the address SHALL be computed from a per-line base plus the wrapped column.
REQ-027 Without BG_FETCH_SCROLL_EN, the scroll_x port SHALL be absent and the behaviour SHALL be REQ-016 unchanged.

Verification
REQ-028 Reset release, pix_ready=1, frame_start pulse, H_ACTIVE=4, V_ACTIVE=2, memory word = address -> pix_data 0..7 in order; sof on 0; eol on 3 and 7; busy falls after the last pixel.
REQ-029 pix_ready=0 for 10 cycles after frame_start -> exactly FIFO_DEPTH (4) reads issue and chipselect then stays 0; on pix_ready=1 the stream resumes with no gap or duplicate.
REQ-030 Random pix_ready toggling over a full 640x480 frame -> 307200 pixels delivered; the last address is 307199 (0x4AFFF); no FIFO overflow.
REQ-031 Second frame_start during FETCH -> ignored; pixel count is unchanged at 8 (4x2 config).
REQ-032 rst_n pulled low mid-line (after pixel 5) -> outputs are 0 immediately; after release plus frame_start, the first pixel is 0 with sof=1.
REQ-033 BG_FETCH_SCROLL_EN defined, scroll_x=3, 4x2 config -> line 0 yields words 3,0,1,2 and line 1 yields words 7,4,5,6.
